// File: rtl/pipe_stage_argmax_seq.sv
// ---------------------------------------------------------------------------
// pipe_stage_argmax_seq
//
// Stage sequencer for the similarity pipeline. Accepted input beats are
// counted and mapped onto programmable stages. While in MAX_STAGE, each lane
// keeps a running fp16 maximum score and the id that produced it. While in
// THR_STAGE, each lane flags whether its score exceeds THRESH. When the pass
// moves past MAX_STAGE, the per-lane {max, id} pairs are offered on a
// valid/ready result port. The current stage also drives a tile mode select.
//
// Ports
//   clk             rising-edge clock
//   rst_n           asynchronous active-low reset
//   start           pulse: begin a pass (ignored while running)
//   stage_boundary  packed boundaries b[k] = [k*STEP_W +: STEP_W], latched at start
//   in_valid        input beat valid
//   in_ready        input beat accepted when in_valid & in_ready
//   score           LANES packed fp16 scores (lane l at [l*WIDTH +: WIDTH])
//   id              LANES packed candidate ids
//   stage           current stage
//   mode            MODE_MASK[stage]
//   finished        stage == NUM_STAGES-1
//   hit             per-lane threshold flags from the last THR_STAGE beat
//   res_valid       argmax result valid
//   res_ready       argmax result consumed when res_valid & res_ready
//   max_score       per-lane running maximum score
//   max_id          per-lane id of the maximum score
// ---------------------------------------------------------------------------
module pipe_stage_argmax_seq #(
    parameter int                    WIDTH      = 16,
    parameter int                    LANES      = 4,
    parameter int                    NUM_STAGES = 8,
    parameter int                    STEP_W     = 8,
    parameter int                    ID_W       = 16,
    parameter int                    MAX_STAGE  = 5,
    parameter int                    THR_STAGE  = 6,
    parameter logic [WIDTH-1:0]      THRESH     = 16'h3BD7,
    parameter int                    NULL_ID    = 4096,
    parameter logic [NUM_STAGES-1:0] MODE_MASK  = 8'hFD,
    localparam int                   SW         = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               start,
    input  logic [(NUM_STAGES-1)*STEP_W-1:0]   stage_boundary,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [LANES*WIDTH-1:0]             score,
    input  logic [LANES*ID_W-1:0]              id,
    output logic [SW-1:0]                      stage,
    output logic                               mode,
    output logic                               finished,
    output logic [LANES-1:0]                   hit,
    output logic                               res_valid,
    input  logic                               res_ready,
    output logic [LANES*WIDTH-1:0]             max_score,
    output logic [LANES*ID_W-1:0]              max_id
);

    localparam logic [SW-1:0]   MAX_S   = SW'(MAX_STAGE);
    localparam logic [SW-1:0]   THR_S   = SW'(THR_STAGE);
    localparam logic [SW-1:0]   LAST_S  = SW'(NUM_STAGES - 1);
    localparam logic [ID_W-1:0] NULL_V  = ID_W'(NULL_ID);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t              state_reg;
    logic [STEP_W-1:0]   step_reg;
    logic [STEP_W-1:0]   step_next;
    logic [SW-1:0]       stage_reg;
    logic [SW-1:0]       stage_next;
    logic [STEP_W-1:0]   bound_reg [NUM_STAGES-1];
    logic                res_valid_reg;
    logic                accept;
    logic                start_ok;
    logic                leave_max;

    // Strict "a > b" on fp16 using the total order of sign-magnitude values.
    // Both zeros compare equal and a NaN candidate never wins.
    function automatic logic fp_gt(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic             a_nan;
        logic             b_nan;
        logic [WIDTH-1:0] ka;
        logic [WIDTH-1:0] kb;
        a_nan = (&a[WIDTH-2:WIDTH-6]) && (|a[WIDTH-7:0]);
        b_nan = (&b[WIDTH-2:WIDTH-6]) && (|b[WIDTH-7:0]);
        // Map to an unsigned key whose ordering matches the numeric ordering.
        ka = a[WIDTH-1] ? ~a : {1'b1, a[WIDTH-2:0]};
        kb = b[WIDTH-1] ? ~b : {1'b1, b[WIDTH-2:0]};
        if (a_nan)
            return 1'b0;
        if ((a[WIDTH-2:0] == '0) && (b[WIDTH-2:0] == '0))
            return 1'b0;
        return b_nan || (ka > kb);
    endfunction

    assign start_ok = start && (state_reg != ST_RUN);
    assign accept   = (state_reg == ST_RUN) && !res_valid_reg && in_valid;
    assign step_next = step_reg + STEP_W'(1);

    // Stage is the number of boundaries the new step count has passed; equal
    // boundaries are passed together, which skips a stage.
    always_comb begin
        int cnt;
        cnt = 0;
        for (int k = 0; k < NUM_STAGES - 1; k++) begin
            if (step_next > bound_reg[k])
                cnt = cnt + 1;
        end
        stage_next = SW'(cnt);
    end

    // Also fires if equal boundaries jump straight over MAX_STAGE, so a result
    // (max=0, id=NULL_ID) is still published for that pass.
    assign leave_max = accept && (stage_reg <= MAX_S) && (stage_next > MAX_S);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            step_reg      <= '0;
            stage_reg     <= '0;
            res_valid_reg <= 1'b0;
            for (int k = 0; k < NUM_STAGES - 1; k++)
                bound_reg[k] <= '0;
        end else begin
            case (state_reg)
                ST_IDLE, ST_DONE: begin
                    if (start_ok) begin
                        state_reg     <= ST_RUN;
                        step_reg      <= '0;
                        stage_reg     <= '0;
                        res_valid_reg <= 1'b0;
                        for (int k = 0; k < NUM_STAGES - 1; k++)
                            bound_reg[k] <= stage_boundary[k*STEP_W +: STEP_W];
                    end else if (res_valid_reg && res_ready) begin
                        res_valid_reg <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (accept) begin
                        step_reg  <= step_next;
                        stage_reg <= stage_next;
                        if (stage_next == LAST_S)
                            state_reg <= ST_DONE;
                        if (leave_max)
                            res_valid_reg <= 1'b1;
                    end else if (res_valid_reg && res_ready) begin
                        res_valid_reg <= 1'b0;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            logic [WIDTH-1:0] max_reg;
            logic [ID_W-1:0]  id_reg;
            logic             hit_reg;
            logic [WIDTH-1:0] lane_score;

            assign lane_score = score[gi*WIDTH +: WIDTH];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    max_reg <= '0;
                    id_reg  <= NULL_V;
                    hit_reg <= 1'b0;
                end else if (start_ok) begin
                    max_reg <= '0;
                    id_reg  <= NULL_V;
                    hit_reg <= 1'b0;
                end else if (accept) begin
                    // Strict compare: a tie keeps the earlier id.
                    if (stage_reg == MAX_S && fp_gt(lane_score, max_reg)) begin
                        max_reg <= lane_score;
                        id_reg  <= id[gi*ID_W +: ID_W];
                    end
                    if (stage_reg == THR_S)
                        hit_reg <= fp_gt(lane_score, THRESH);
                end
            end

            assign max_score[gi*WIDTH +: WIDTH] = max_reg;
            assign max_id[gi*ID_W +: ID_W]      = id_reg;
            assign hit[gi]                      = hit_reg;
        end
    endgenerate

    assign in_ready  = (state_reg == ST_RUN) && !res_valid_reg;
    assign stage     = stage_reg;
    assign mode      = MODE_MASK[stage_reg];
    assign finished  = (stage_reg == LAST_S);
    assign res_valid = res_valid_reg;

endmodule
